// File: rtl/seq_det_pkg.sv
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared constants and helpers for the programmable detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    // Width needed to hold a pattern length in the range 0..max_len.
    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam logic [31:0] FLAG_0111110 = 32'h0000_003E;
    localparam int          FLAG_LEN     = 7;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

endpackage

`default_nettype wire

// File: rtl/seq_match_cmp.sv
// ============================================================================
//  Module      : seq_match_cmp
//  Description : Masked compare of the low len bits of history vs pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_match_cmp #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic [MAX_LEN-1:0] sr,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match_raw
);

    logic [MAX_LEN-1:0] w_mask;

    for (genvar k = 0; k < MAX_LEN; k++) begin : g_mask
        assign w_mask[k] = (LEN_W'(k) < len);
    end

    assign match_raw = ~|((sr ^ pattern) & w_mask);

endmodule

`default_nettype wire

// File: rtl/seq_detector_prog.sv
// ============================================================================
//  Module      : seq_detector_prog
//  Description : Runtime-programmable serial pattern detector with hit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 16,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(FLAG_0111110),
    parameter int                 DEF_LEN     = FLAG_LEN,
    parameter logic               DEF_OVL     = OVL_ON,
    localparam int                LEN_W       = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               i,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               hit,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] c_FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] r_sr;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_cfg_err;
    logic               r_hit;
    logic [CNT_W-1:0]   r_hit_cnt;

    logic [MAX_LEN-1:0] w_sr_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic               w_match_raw;
    logic               w_match;
    logic               w_fire;
    logic               w_len_bad;

    assign w_sr_next   = {r_sr[MAX_LEN-2:0], i};
    assign w_fill_next = (r_fill == c_FILL_MAX) ? r_fill : r_fill + 1'b1;
    assign w_len_bad   = (cfg_len == '0) || (cfg_len > c_FILL_MAX);

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .sr        (w_sr_next),
        .pattern   (r_pattern),
        .len       (r_len),
        .match_raw (w_match_raw)
    );

    // The fill guard keeps stale zeros in the history from forming a match.
    assign w_match = !r_cfg_err && (w_fill_next >= r_len) && w_match_raw;
    assign w_fire  = en && !cfg_load && w_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr      <= '0;
            r_fill    <= '0;
            r_pattern <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_ovl     <= DEF_OVL;
            r_cfg_err <= 1'b0;
            r_hit     <= 1'b0;
        end else if (cfg_load) begin
            r_sr      <= '0;
            r_fill    <= '0;
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_ovl     <= cfg_ovl;
            r_cfg_err <= w_len_bad;
            r_hit     <= 1'b0;
        end else if (en) begin
            r_sr   <= w_sr_next;
            r_fill <= (w_match && (r_ovl == OVL_OFF)) ? '0 : w_fill_next;
            r_hit  <= w_match;
        end else begin
            r_hit <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt <= '0;
        end else if (cnt_clr) begin
            r_hit_cnt <= w_fire ? CNT_W'(1) : '0;
        end else if (w_fire && (r_hit_cnt != c_CNT_MAX)) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign hit     = r_hit;
    assign hit_cnt = r_hit_cnt;
    assign cfg_err = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
// ============================================================================
//  Module      : tb_seq_detector_prog
//  Description : Self-checking bench for seq_detector_prog (8- and 2-bit counters).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_prog;

    localparam int MAXL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, i = 1'b0, cfg_load = 1'b0, cnt_clr = 1'b0, cfg_ovl = 1'b0;
    logic [15:0] cfg_pattern = '0;
    logic [4:0]  cfg_len = '0;
    logic        hit, hit2, cfg_err, cfg_err2;
    logic [7:0]  hit_cnt;
    logic [1:0]  hit_cnt2;

    // Model: history as a queue of bits since the last flush, newest at the back.
    bit          hist[$];
    logic [15:0] m_pat;
    int          m_len, m_cnt, m_cnt2;
    bit          m_ovl, m_err, m_hit;
    int          n_checks = 0;
    int          n_fail = 0;

    seq_detector_prog dut (
        .clk(clk), .rst(rst), .en(en), .i(i), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .cnt_clr(cnt_clr), .hit(hit), .hit_cnt(hit_cnt), .cfg_err(cfg_err)
    );

    seq_detector_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .i(i), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .cnt_clr(cnt_clr), .hit(hit2), .hit_cnt(hit_cnt2), .cfg_err(cfg_err2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected completion");
        $fatal(1);
    end

    task automatic model_reset();
        hist.delete();
        m_pat = 16'h003E; m_len = 7; m_ovl = 1'b1; m_err = 1'b0;
        m_hit = 1'b0; m_cnt = 0; m_cnt2 = 0;
    endtask

    // Drives one clock of stimulus and advances the model; returns #1 after the edge.
    task automatic cyc(input bit e, input bit b, input bit ld, input bit clr);
        bit fire;
        fire = 1'b0;
        en = e; i = b; cfg_load = ld; cnt_clr = clr;
        if (ld) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_ovl;
            m_err = (cfg_len == 0) || (int'(cfg_len) > MAXL);
            hist.delete();
            m_hit = 1'b0;
        end else if (e) begin
            hist.push_back(b);
            if (hist.size() > MAXL) void'(hist.pop_front());
            fire = !m_err && (hist.size() >= m_len);
            for (int k = 0; k < m_len && fire; k++)
                if (hist[hist.size() - 1 - k] != m_pat[k]) fire = 1'b0;
            m_hit = fire;
            if (fire && !m_ovl) hist.delete();
        end else begin
            m_hit = 1'b0;
        end
        if (clr) begin
            m_cnt = int'(fire); m_cnt2 = int'(fire);
        end else if (fire) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        @(posedge clk); #1;
        en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [15:0] p, input logic [4:0] l, input bit o);
        cfg_pattern = p; cfg_len = l; cfg_ovl = o;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        n_checks++;
        if (hit !== 1'b0 || hit_cnt !== 8'd0 || cfg_err !== 1'b0 || hit_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: got hit=%b cnt=%0d err=%b cnt2=%0d, expected 0 0 0 0",
                     hit, hit_cnt, cfg_err, hit_cnt2);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_flag_ovl();
        string s = "0111110111110";
        int nh = 0;
        for (int k = 0; k < s.len(); k++) begin
            cyc(1'b1, s[k] == "1", 1'b0, 1'b0);
            nh += int'(hit);
            n_checks++;
            if (hit !== m_hit || hit2 !== m_hit) begin
                n_fail++;
                $display("FAIL flag_ovl hit bit %0d: got %b/%b expected %b", k + 1, hit, hit2, m_hit);
            end
        end
        n_checks++;
        if (nh != 2 || hit_cnt !== 8'd2 || m_cnt != 2) begin
            n_fail++;
            $display("FAIL flag_ovl count: got hits=%0d cnt=%0d expected 2 2", nh, hit_cnt);
        end
    endtask

    task automatic test_flag_novl();
        string s = "0111110111110";
        int nh = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        load(16'h003E, 5'd7, 1'b0);
        for (int k = 0; k < s.len() + 6; k++) begin
            cyc(1'b1, (k >= s.len()) ? 1'b1 : (s[k] == "1"), 1'b0, 1'b0);
            nh += int'(hit);
            n_checks++;
            if (hit !== m_hit) begin
                n_fail++;
                $display("FAIL flag_novl hit bit %0d: got %b expected %b", k + 1, hit, m_hit);
            end
        end
        n_checks++;
        if (nh != 1 || hit_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL flag_novl count: got hits=%0d cnt=%0d expected 1 1", nh, hit_cnt);
        end
    endtask

    task automatic test_short();
        string s = "10101";
        for (int m = 1; m >= 0; m--) begin
            int nh = 0;
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            load(16'h0005, 5'd3, bit'(m));
            for (int k = 0; k < s.len(); k++) begin
                cyc(1'b1, s[k] == "1", 1'b0, 1'b0);
                nh += int'(hit);
                n_checks++;
                if (hit !== m_hit) begin
                    n_fail++;
                    $display("FAIL short ovl=%0d bit %0d: got %b expected %b", m, k + 1, hit, m_hit);
                end
            end
            n_checks++;
            if (nh != (m ? 2 : 1) || int'(hit_cnt) != nh) begin
                n_fail++;
                $display("FAIL short ovl=%0d count: got hits=%0d cnt=%0d expected %0d", m, nh, hit_cnt, m ? 2 : 1);
            end
        end
    endtask

    task automatic test_gaps_flush();
        string s = "0111110";
        bit last;
        load(16'h003E, 5'd7, 1'b1);
        for (int k = 0; k < s.len(); k++) begin
            cyc(1'b1, s[k] == "1", 1'b0, 1'b0);
            last = hit;
            n_checks++;
            if (hit !== m_hit) begin
                n_fail++;
                $display("FAIL gaps bit %0d: got %b expected %b", k + 1, hit, m_hit);
            end
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (hit !== 1'b0) begin
                n_fail++;
                $display("FAIL gaps idle %0d: got %b expected 0", k + 1, hit);
            end
        end
        n_checks++;
        if (last !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps final: got %b expected 1", last);
        end
        for (int k = 0; k < 4; k++) cyc(1'b1, s[k] == "1", 1'b0, 1'b0);
        load(16'h003E, 5'd7, 1'b1);
        for (int k = 4; k < 7; k++) begin
            cyc(1'b1, s[k] == "1", 1'b0, 1'b0);
            n_checks++;
            if (hit !== 1'b0 || m_hit) begin
                n_fail++;
                $display("FAIL flush bit %0d: got %b expected 0", k + 1, hit);
            end
        end
    endtask

    task automatic test_counter();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (hit_cnt !== 8'd0 || hit_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL clr_alone: got %0d/%0d expected 0/0", hit_cnt, hit_cnt2);
        end
        load(16'h0001, 5'd1, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (hit_cnt !== 8'd5 || hit_cnt2 !== 2'd3 || hit !== 1'b1) begin
            n_fail++;
            $display("FAIL sat2: got cnt=%0d cnt2=%0d hit=%b expected 5 3 1", hit_cnt, hit_cnt2, hit);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (hit_cnt !== 8'd1 || hit_cnt2 !== 2'd1) begin
            n_fail++;
            $display("FAIL clr_with_match: got %0d/%0d expected 1/1", hit_cnt, hit_cnt2);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (hit_cnt !== 8'd0 || hit_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL clr_again: got %0d/%0d expected 0/0", hit_cnt, hit_cnt2);
        end
        for (int k = 0; k < 300; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (hit_cnt !== 8'd255 || hit_cnt2 !== 2'd3 || m_cnt != 255) begin
            n_fail++;
            $display("FAIL sat8: got %0d/%0d expected 255/3", hit_cnt, hit_cnt2);
        end
    endtask

    task automatic test_cfg_err();
        string s = "0111110";
        logic [4:0] bad[2];
        bad[0] = 5'd0; bad[1] = 5'd17;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 2; b++) begin
            load(16'h003E, bad[b], 1'b1);
            for (int k = 0; k < s.len(); k++) begin
                cyc(1'b1, s[k] == "1", 1'b0, 1'b0);
                n_checks++;
                if (hit !== 1'b0 || cfg_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cfg_err len=%0d bit %0d: got hit=%b err=%b expected 0 1",
                             bad[b], k + 1, hit, cfg_err);
                end
            end
        end
        load(16'h003E, 5'd7, 1'b1);
        n_checks++;
        if (cfg_err !== 1'b0 || hit_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL cfg_err clear: got err=%b cnt=%0d expected 0 0", cfg_err, hit_cnt);
        end
    endtask

    task automatic test_rst_mid();
        string s = "01111100111110";
        int nh = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        load(16'h0001, 5'd1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        load(16'h003E, 5'd7, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b1, s[k] == "1", 1'b0, 1'b0);
        #2; rst = 1'b1; #1;
        model_reset();
        n_checks++;
        if (hit !== 1'b0 || hit_cnt !== 8'd0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got hit=%b cnt=%0d err=%b expected 0 0 0", hit, hit_cnt, cfg_err);
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 5; k < s.len(); k++) begin
            cyc(1'b1, s[k] == "1", 1'b0, 1'b0);
            nh += int'(hit);
            n_checks++;
            if (hit !== m_hit) begin
                n_fail++;
                $display("FAIL rst_mid bit %0d: got %b expected %b", k + 1, hit, m_hit);
            end
        end
        n_checks++;
        if (nh != 1 || hit_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL rst_mid count: got hits=%0d cnt=%0d expected 1 1", nh, hit_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) begin
                logic [4:0] l;
                l = (($urandom_range(0, 9)) == 0) ? 5'(($urandom_range(0, 1)) * 17)
                                                 : 5'($urandom_range(1, 5));
                load(16'($urandom), l, bit'($urandom_range(0, 1)));
            end else begin
                cyc(($urandom_range(0, 3)) != 0, bit'($urandom_range(0, 1)), 1'b0,
                    ($urandom_range(0, 39)) == 0);
            end
            n_checks++;
            if (hit !== m_hit || cfg_err !== m_err) begin
                n_fail++;
                $display("FAIL random cyc %0d: got hit=%b err=%b expected %b %b", c, hit, cfg_err, m_hit, m_err);
            end
            n_checks++;
            if (int'(hit_cnt) != m_cnt || int'(hit_cnt2) != m_cnt2) begin
                n_fail++;
                $display("FAIL random cnt cyc %0d: got %0d/%0d expected %0d/%0d", c, hit_cnt, hit_cnt2, m_cnt, m_cnt2);
            end
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_flag_ovl();
        test_flag_novl();
        test_short();
        test_gaps_flush();
        test_counter();
        test_cfg_err();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
